// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants; the bit generator imports the same bounds.
package vga_pkg;
    localparam int COUNT_W = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Half-open window test: lo <= count < hi.
    function automatic logic inWindow(input logic [COUNT_W-1:0] count, input int lo, input int hi);
        return (int'(count) >= lo) && (int'(count) < hi);
    endfunction
endpackage

// File: rtl/pix_clk_en.sv
// Divides the system clock into a one-clk pixel enable; tick marks the clock on which pixEn rises.
module pix_clk_en #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic tick,
    output logic pixEn
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] divCnt;

    // With CLK_DIV=1 DIV_LAST is 0, so tick stays high and pixEn is held after reset.
    assign tick = (divCnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divCnt <= '0;
            pixEn  <= 1'b0;
        end else begin
            divCnt <= tick ? '0 : divCnt + DIV_W'(1);
            pixEn  <= tick;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel enable, h/v counters and zero-skew registered sync/blank/strobe outputs.
module vga_timing_gen #(
    parameter int   CLK_DIV   = 2,
    parameter int   H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int   H_FRONT   = vga_pkg::H_FRONT,
    parameter int   H_SYNC    = vga_pkg::H_SYNC,
    parameter int   H_BACK    = vga_pkg::H_BACK,
    parameter int   V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int   V_FRONT   = vga_pkg::V_FRONT,
    parameter int   V_SYNC    = vga_pkg::V_SYNC,
    parameter int   V_BACK    = vga_pkg::V_BACK,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixEn,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync,
    output logic       lineStart,
    output logic       frameStart,
    output logic       vBlank
);
    import vga_pkg::*;

    localparam int hTotal   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int vTotal   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int hSyncLo  = H_VISIBLE + H_FRONT;
    localparam int hSyncHi  = hSyncLo + H_SYNC;
    localparam int vSyncLo  = V_VISIBLE + V_FRONT;
    localparam int vSyncHi  = vSyncLo + V_SYNC;
    localparam logic [COUNT_W-1:0] hLast = COUNT_W'(hTotal - 1);
    localparam logic [COUNT_W-1:0] vLast = COUNT_W'(vTotal - 1);

    logic               tick;
    logic [COUNT_W-1:0] hNext;
    logic [COUNT_W-1:0] vNext;
    logic               hWrap;
    logic               vWrap;

    pix_clk_en #(
        .CLK_DIV(CLK_DIV)
    ) uPixClkEn (
        .clk  (clk),
        .reset(reset),
        .tick (tick),
        .pixEn(pixEn)
    );

    // Next raster position; the counters load it on the same edge that raises pixEn.
    always_comb begin
        hNext = hCount;
        vNext = vCount;
        hWrap = 1'b0;
        vWrap = 1'b0;
        if (tick) begin
            if (hCount == hLast) begin
                hNext = '0;
                hWrap = 1'b1;
                if (vCount == vLast) begin
                    vNext = '0;
                    vWrap = 1'b1;
                end else begin
                    vNext = vCount + COUNT_W'(1);
                end
            end else begin
                hNext = hCount + COUNT_W'(1);
            end
        end
    end

    // Decoding from hNext/vNext keeps every flag aligned with the counter it describes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hCount     <= hLast;
            vCount     <= vLast;
            bright     <= 1'b0;
            vBlank     <= 1'b1;
            hSync      <= ~SYNC_POL;
            vSync      <= ~SYNC_POL;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            hCount     <= hNext;
            vCount     <= vNext;
            bright     <= inWindow(hNext, 0, H_VISIBLE) && inWindow(vNext, 0, V_VISIBLE);
            vBlank     <= !inWindow(vNext, 0, V_VISIBLE);
            hSync      <= inWindow(hNext, hSyncLo, hSyncHi) ? SYNC_POL : ~SYNC_POL;
            vSync      <= inWindow(vNext, vSyncLo, vSyncHi) ? SYNC_POL : ~SYNC_POL;
            lineStart  <= hWrap;
            frameStart <= hWrap && vWrap;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size timing (A), a reduced raster (B, CLK_DIV=2) and the same raster with CLK_DIV=1 (C).
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rstA = 1'b0;
    logic rstB = 1'b0;
    logic rstC = 1'b0;

    logic       aPixEn, aBright, aHSync, aVSync, aLine, aFrame, aVBlank;
    logic [9:0] aH, aV;
    logic       bPixEn, bBright, bHSync, bVSync, bLine, bFrame, bVBlank;
    logic [9:0] bH, bV;
    logic       cPixEn, cBright, cHSync, cVSync, cLine, cFrame, cVBlank;
    logic [9:0] cH, cV;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_timing_gen dutA (
        .clk(clk), .reset(rstA), .pixEn(aPixEn), .hCount(aH), .vCount(aV),
        .bright(aBright), .hSync(aHSync), .vSync(aVSync),
        .lineStart(aLine), .frameStart(aFrame), .vBlank(aVBlank)
    );

    // Reduced raster: H total 15 (sync 10..12), V total 11 (sync 7..8, blank 6..10).
    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) dutB (
        .clk(clk), .reset(rstB), .pixEn(bPixEn), .hCount(bH), .vCount(bV),
        .bright(bBright), .hSync(bHSync), .vSync(bVSync),
        .lineStart(bLine), .frameStart(bFrame), .vBlank(bVBlank)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) dutC (
        .clk(clk), .reset(rstC), .pixEn(cPixEn), .hCount(cH), .vCount(cV),
        .bright(cBright), .hSync(cHSync), .vSync(cVSync),
        .lineStart(cLine), .frameStart(cFrame), .vBlank(cVBlank)
    );

    // Steps clocks until the selected DUT shows pixEn; reports gap and whether strobes stayed low meanwhile.
    task automatic waitPix(input int which, output int gap, output bit ok, output bit quiet);
        logic pe, ls, fs;
        gap = 0;
        ok = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            gap++;
            case (which)
                0:       begin pe = aPixEn; ls = aLine; fs = aFrame; end
                1:       begin pe = bPixEn; ls = bLine; fs = bFrame; end
                default: begin pe = cPixEn; ls = cLine; fs = cFrame; end
            endcase
            if (pe) begin
                ok = 1'b1;
                return;
            end
            if (ls || fs) quiet = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (aH !== 10'd799 || aV !== 10'd524) begin
            failures++;
            $display("FAIL reset_counts h=%0d v=%0d required 799 524", aH, aV);
        end
        checks++;
        if (aBright !== 1'b0 || aVBlank !== 1'b1 || aHSync !== 1'b1 || aVSync !== 1'b1) begin
            failures++;
            $display("FAIL reset_levels bright=%b vBlank=%b hSync=%b vSync=%b required 0 1 1 1",
                     aBright, aVBlank, aHSync, aVSync);
        end
        checks++;
        if (aPixEn !== 1'b0 || aLine !== 1'b0 || aFrame !== 1'b0 || cPixEn !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes pixEn=%b line=%b frame=%b cPixEn=%b required 0 0 0 0",
                     aPixEn, aLine, aFrame, cPixEn);
        end
        rstA = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (aPixEn !== 1'b0 || aH !== 10'd799 || aFrame !== 1'b0) begin
            failures++;
            $display("FAIL release_clk1 pixEn=%b h=%0d frame=%b required 0 799 0", aPixEn, aH, aFrame);
        end
        @(posedge clk);
        #1;
        checks++;
        if (aPixEn !== 1'b1 || aH !== 10'd0 || aV !== 10'd0) begin
            failures++;
            $display("FAIL release_clk2 pixEn=%b h=%0d v=%0d required 1 0 0", aPixEn, aH, aV);
        end
        checks++;
        if (aFrame !== 1'b1 || aLine !== 1'b1 || aBright !== 1'b1 || aVBlank !== 1'b0) begin
            failures++;
            $display("FAIL release_flags frame=%b line=%b bright=%b vBlank=%b required 1 1 1 0",
                     aFrame, aLine, aBright, aVBlank);
        end
    endtask

    task automatic test_line();
        int gap, expH, expV, syncLow;
        bit ok, quiet;
        logic expSync, expBright, expLine;
        syncLow = 0;
        for (int i = 1; i <= 800; i++) begin
            waitPix(0, gap, ok, quiet);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL line_timeout pixel=%0d pixEn=0 required 1 within 16 clks", i);
                return;
            end
            expH = i % 800;
            expV = i / 800;
            expSync = !(expH >= 656 && expH < 752);
            expBright = (expH < 640);
            expLine = (expH == 0);
            checks++;
            if (gap !== 2) begin
                failures++;
                $display("FAIL line_period pixel=%0d gap=%0d required 2", i, gap);
            end
            checks++;
            if (!quiet) begin
                failures++;
                $display("FAIL line_idle_strobe pixel=%0d strobe=1 required 0 between pixEn", i);
            end
            checks++;
            if (aH !== 10'(expH) || aV !== 10'(expV)) begin
                failures++;
                $display("FAIL line_count h=%0d v=%0d required %0d %0d", aH, aV, expH, expV);
            end
            checks++;
            if (aHSync !== expSync) begin
                failures++;
                $display("FAIL line_hsync h=%0d hSync=%b required %b", expH, aHSync, expSync);
            end
            if (aHSync === 1'b0) syncLow++;
            checks++;
            if (aBright !== expBright) begin
                failures++;
                $display("FAIL line_bright h=%0d bright=%b required %b", expH, aBright, expBright);
            end
            checks++;
            if (aLine !== expLine || aFrame !== 1'b0) begin
                failures++;
                $display("FAIL line_strobe h=%0d line=%b frame=%b required %b 0", expH, aLine, aFrame, expLine);
            end
        end
        checks++;
        if (syncLow !== 96) begin
            failures++;
            $display("FAIL line_hsync_width low=%0d required 96", syncLow);
        end
    endtask

    task automatic test_midline_reset();
        int gap;
        bit ok, quiet, found;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            waitPix(0, gap, ok, quiet);
            if (ok && aH == 10'd700) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL midline_reach h=%0d required 700", aH);
        end
        rstA = 1'b0;
        #1;
        checks++;
        if (aH !== 10'd799 || aV !== 10'd524) begin
            failures++;
            $display("FAIL midline_counts h=%0d v=%0d required 799 524", aH, aV);
        end
        checks++;
        if (aHSync !== 1'b1 || aVSync !== 1'b1 || aBright !== 1'b0 || aVBlank !== 1'b1) begin
            failures++;
            $display("FAIL midline_levels hSync=%b vSync=%b bright=%b vBlank=%b required 1 1 0 1",
                     aHSync, aVSync, aBright, aVBlank);
        end
        checks++;
        if (aPixEn !== 1'b0 || aLine !== 1'b0 || aFrame !== 1'b0) begin
            failures++;
            $display("FAIL midline_strobes pixEn=%b line=%b frame=%b required 0 0 0", aPixEn, aLine, aFrame);
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        bit ok, quiet;
        repeat (3) @(posedge clk);
        #1;
        rstA = 1'b1;
        waitPix(0, gap, ok, quiet);
        checks++;
        if (!ok || gap !== 2) begin
            failures++;
            $display("FAIL rerelease_latency ok=%b gap=%0d required 1 2", ok, gap);
        end
        checks++;
        if (aH !== 10'd0 || aV !== 10'd0 || aFrame !== 1'b1 || aLine !== 1'b1) begin
            failures++;
            $display("FAIL rerelease_wrap h=%0d v=%0d frame=%b line=%b required 0 0 1 1", aH, aV, aFrame, aLine);
        end
    endtask

    task automatic test_frame();
        int gap, n, expH, expV;
        bit ok, quiet, done;
        logic expHS, expVS, expBright, expVB, expFrame;
        rstB = 1'b1;
        waitPix(1, gap, ok, quiet);
        checks++;
        if (!ok || bFrame !== 1'b1 || bH !== 10'd0 || bV !== 10'd0) begin
            failures++;
            $display("FAIL frame_first ok=%b frame=%b h=%0d v=%0d required 1 1 0 0", ok, bFrame, bH, bV);
        end
        expH = 0;
        expV = 0;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            waitPix(1, gap, ok, quiet);
            if (!ok) break;
            n++;
            expH++;
            if (expH == 15) begin
                expH = 0;
                expV = (expV == 10) ? 0 : expV + 1;
            end
            expHS = !(expH >= 10 && expH < 13);
            expVS = !(expV >= 7 && expV < 9);
            expBright = (expH < 8) && (expV < 6);
            expVB = (expV >= 6);
            expFrame = (expH == 0) && (expV == 0);
            checks++;
            if (bH !== 10'(expH) || bV !== 10'(expV)) begin
                failures++;
                $display("FAIL frame_count h=%0d v=%0d required %0d %0d", bH, bV, expH, expV);
            end
            checks++;
            if (bHSync !== expHS || bVSync !== expVS) begin
                failures++;
                $display("FAIL frame_sync h=%0d v=%0d hSync=%b vSync=%b required %b %b",
                         expH, expV, bHSync, bVSync, expHS, expVS);
            end
            checks++;
            if (bBright !== expBright || bVBlank !== expVB) begin
                failures++;
                $display("FAIL frame_blank h=%0d v=%0d bright=%b vBlank=%b required %b %b",
                         expH, expV, bBright, bVBlank, expBright, expVB);
            end
            checks++;
            if (bFrame !== expFrame || !quiet) begin
                failures++;
                $display("FAIL frame_strobe h=%0d v=%0d frame=%b quiet=%b required %b 1",
                         expH, expV, bFrame, quiet, expFrame);
            end
            if (bFrame === 1'b1) done = 1'b1;
        end
        checks++;
        if (n !== 165 || !done) begin
            failures++;
            $display("FAIL frame_length pixEn=%0d done=%b required 165 1", n, done);
        end
    endtask

    task automatic test_wrap_corner();
        int gap;
        bit ok, quiet, found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            waitPix(1, gap, ok, quiet);
            if (ok && bH == 10'd14 && bV == 10'd10) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL corner_reach h=%0d v=%0d required 14 10", bH, bV);
        end
        waitPix(1, gap, ok, quiet);
        checks++;
        if (!ok || bH !== 10'd0 || bV !== 10'd0 || bFrame !== 1'b1 || bLine !== 1'b1) begin
            failures++;
            $display("FAIL corner_wrap h=%0d v=%0d frame=%b line=%b required 0 0 1 1", bH, bV, bFrame, bLine);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bFrame !== 1'b0 || bLine !== 1'b0 || bH !== 10'd0 || bPixEn !== 1'b0) begin
            failures++;
            $display("FAIL corner_one_clk frame=%b line=%b h=%0d pixEn=%b required 0 0 0 0",
                     bFrame, bLine, bH, bPixEn);
        end
    endtask

    task automatic test_clkdiv1();
        int k, low;
        rstC = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cPixEn !== 1'b1 || cH !== 10'd0 || cV !== 10'd0 || cFrame !== 1'b1) begin
            failures++;
            $display("FAIL div1_first pixEn=%b h=%0d v=%0d frame=%b required 1 0 0 1", cPixEn, cH, cV, cFrame);
        end
        k = 0;
        low = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (cPixEn !== 1'b1) low++;
            if (cFrame === 1'b1) break;
        end
        checks++;
        if (k !== 165 || low !== 0) begin
            failures++;
            $display("FAIL div1_frame clks=%0d pixEnLow=%0d required 165 0", k, low);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_midline_reset();
        test_back_to_back();
        test_frame();
        test_wrap_corner();
        test_clkdiv1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
